mem_arbiter4: RTL and testbench
===============================

Name: mem_arbiter4

Overview:
- Round-robin arbiter that shares one single-port memory subsystem among four processor tiles. Each tile is an ALU, instruction unit and memory-interface unit.
- Sits between the four memory-interface units (cs/read_req/write_req/addrout/datatomem) and the memory subsystem's single request/response port.
- Serialises accesses one at a time, routes read data back, and returns a one-cycle per-requester response pulse.

Parameters:
- NREQ, 4, number of requesters (the RTL supports only 4; kept for readability).
- AW, 14, address width.
- DW, 16, write-data width.
- RW, 8, read-data width.
- TIMEOUT_CYCLES, 64, response watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req  in  4  per-requester access request (cs from each memory-interface unit)
- rd  in  4  per-requester read request
- wr  in  4  per-requester write request
- addr  in  4*AW  packed addresses; requester i uses bits [i*AW +: AW]
- wdata  in  4*DW  packed write data; requester i uses bits [i*DW +: DW]
- resp  out  4  one-cycle completion pulse, one bit per requester
- rdata  out  RW  read data from the last completed read (shared bus)
- grant  out  4  one-hot owner of the current transaction; 0 when idle
- mem_re  out  1  memory read strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  RW  memory read data, valid when mem_resp=1
- mem_resp  in  1  memory completion
- err  out  1  sticky watchdog error (held 0 when the optional feature is off)

Behaviour:
- Reset (async, reset_n=0): resp=0, rdata=0, grant=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, err=0, state=IDLE. Round-robin pointer last=3, so requester 0 wins first. Reset mid-transaction abandons the access with no resp pulse.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If req!=0, pick the winner: first i with req[i]=1, scanning from (last+1) mod 4 upward with wrap.
  - Register grant, mem_addr, mem_wdata and the op, then go to ACCESS.
  - Latency: req sampled high in cycle N gives strobe high in cycle N+1.
- Op selection in IDLE:
  - wr[i]=1 gives a write (mem_we=1), even if rd[i]=1 too; write wins.
  - rd[i]=1 only gives a read (mem_re=1).
  - req[i]=1 with rd=wr=0 is skipped and not granted; the scan continues to the next requester.
- ACCESS:
  - Strobe, mem_addr, mem_wdata and grant held stable until mem_resp=1.
  - Requester inputs are ignored; deasserting req mid-access does not cancel the access.
- On mem_resp=1 in ACCESS:
  - Drop the strobe next cycle.
  - For reads, capture mem_rdata into rdata.
  - Go to DONE.
- mem_resp in IDLE or DONE is ignored.
- DONE (one cycle):
  - resp[g]=1 for exactly one cycle; grant still equals the owner.
  - last=g; then IDLE.
  - rdata holds its value until the next read completes.
- Throughput: at most one access per 3 cycles (IDLE→ACCESS→DONE) with zero-wait memory.
- Fairness: with all four requesting continuously, grant order is 0,1,2,3,0… and no requester waits more than 3 other accesses.
- Requesters must drop req in the cycle after their resp. A req still high in IDLE after DONE is treated as a new request.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - Counter cleared on entry to ACCESS, incremented each ACCESS cycle.
  - When it reaches TIMEOUT_CYCLES with no mem_resp: drop the strobe, set err=1 (sticky until reset), pulse resp[g] with rdata unchanged, go DONE.
- Not defined: no counter, ACCESS waits indefinitely, err tied 0.

Test Plan:
- Single read: req=0001, rd=0001, addr0=0x0123, memory returns 0xA5 after 2 cycles → mem_re high from cycle 1, mem_addr=0x0123, resp=0001 one cycle, rdata=0xA5.
- Single write: requester 2, wr, addr2=0x3FFF, wdata2=0xBEEF → mem_we=1, mem_addr=0x3FFF, mem_wdata=0xBEEF, resp=0100, rdata unchanged.
- Contention: all four requesting reads, after reset → grants 0001,0010,0100,1000,0001 in order; each resp matches its grant.
- Simultaneous rd and wr on requester 1 with wdata=0x00FF → write issued (mem_we=1, mem_re=0), resp=0010.
- Reset mid-access: assert reset_n=0 during ACCESS → all outputs 0 immediately, no resp. Next request from requester 3 alone is granted; with all requesting, requester 0 is granted first.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=64, memory never responds → strobe drops after 64 ACCESS cycles, err=1, resp pulsed, next requester served.

Source files
------------

// File: rtl/mem_arbiter4.sv
// Round-robin arbiter sharing one single-port memory among four tiles.
// Define MEM_ARB_TIMEOUT_EN to add a response watchdog that sets a sticky err.
module mem_arbiter4 #(
  parameter int NREQ           = 4,
  parameter int AW             = 14,
  parameter int DW             = 16,
  parameter int RW             = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   rd,
  input  logic [NREQ-1:0]   wr,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]   resp,
  output logic [RW-1:0]     rdata,
  output logic [NREQ-1:0]   grant,
  output logic              mem_re,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [RW-1:0]     mem_rdata,
  input  logic              mem_resp,
  output logic              err
);

  // Handshake: a requester holds req plus rd/wr and its addr/wdata until it
  // sees its one-cycle resp pulse, then drops req; the arbiter samples the
  // request lines only while idle, so changes during an access are ignored.

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t     state;
  logic [1:0] last;
  logic [1:0] owner;
  logic [1:0] pick;
  logic [1:0] idx;
  logic       found;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr;
`else
  // The limit only matters when the watchdog is built in.
  localparam int timeout_unused = TIMEOUT_CYCLES;
  assign err = 1'b0;
`endif

  // A request without rd or wr is not a valid access and is skipped.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx] && (rd[idx] || wr[idx])) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      last      <= 2'd3;
      owner     <= '0;
      grant     <= '0;
      resp      <= '0;
      rdata     <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      err       <= 1'b0;
      tmr       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          resp <= '0;
          if (found) begin
            owner     <= pick;
            grant     <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
            mem_addr  <= addr[pick*AW +: AW];
            mem_wdata <= wdata[pick*DW +: DW];
            // Write wins when both rd and wr are raised.
            mem_we    <= wr[pick];
            mem_re    <= !wr[pick];
            state     <= ACCESS;
`ifdef MEM_ARB_TIMEOUT_EN
            tmr       <= '0;
`endif
          end
        end
        ACCESS: begin
          if (mem_resp) begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            if (mem_re) rdata <= mem_rdata;
            resp   <= grant;
            state  <= DONE;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (tmr == TW'(TIMEOUT_CYCLES - 1)) begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            err    <= 1'b1;
            resp   <= grant;
            state  <= DONE;
          end else begin
            tmr <= tmr + TW'(1);
          end
`endif
        end
        DONE: begin
          resp  <= '0;
          grant <= '0;
          last  <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter4.sv
// Self-checking bench for mem_arbiter4: directed scenarios plus randomized
// traffic checked against a round-robin reference model.
module tb_mem_arbiter4;
  localparam int AW = 14;
  localparam int DW = 16;
  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [3:0]    req, rd, wr;
  logic [4*AW-1:0] addr;
  logic [4*DW-1:0] wdata;
  logic [3:0]    resp, grant;
  logic [RW-1:0] rdata;
  logic          mem_re, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [RW-1:0] mem_rdata;
  logic          mem_resp;
  logic          err;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter4 dut (
    .clk(clk), .reset_n(reset_n), .req(req), .rd(rd), .wr(wr),
    .addr(addr), .wdata(wdata), .resp(resp), .rdata(rdata), .grant(grant),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .err(err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- memory environment ----------------
  bit [7:0] mem [0:16383];
  bit       hang = 1'b0;
  bit       busy = 1'b0;
  int       wait_cnt = 0;

  initial begin
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!reset_n) begin
        mem_resp = 1'b0;
        busy     = 1'b0;
      end else if (mem_resp) begin
        mem_resp = 1'b0;
        busy     = 1'b0;
      end else if ((mem_re || mem_we) && !hang) begin
        if (!busy) begin
          busy     = 1'b1;
          wait_cnt = $urandom_range(0, 2);
        end
        if (wait_cnt == 0) begin
          mem_resp = 1'b1;
          if (mem_we) mem[mem_addr] = mem_wdata[7:0];
          else        mem_rdata     = mem[mem_addr];
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset_n = 1'b0;
    req = '0; rd = '0; wr = '0; addr = '0; wdata = '0; hang = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input bit r, input bit w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1; rd[i] = r; wr[i] = w;
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic clr_req(input int i);
    req[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0;
  endtask

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (mem_re || mem_we) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (resp != 4'b0000) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- reference model state / scoreboard ----------------
  bit            p_valid [4];
  bit            p_wr    [4];
  logic [AW-1:0] p_addr  [4];
  logic [DW-1:0] p_data  [4];
  int            waits   [4];
  bit [7:0]      ref_mem [0:15];
  logic [RW-1:0] ref_rdata;
  int            m_last;
  logic [3:0]    exp_q[$];

  task automatic refill();
    int r, op, f;
    bit any;
    any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!p_valid[i]) begin
        r = $urandom_range(0, 7);
        if (r < 4) begin
          op = $urandom_range(0, 2);
          p_valid[i] = 1'b1;
          p_wr[i]    = (op != 0);
          p_addr[i]  = AW'($urandom_range(0, 15));
          p_data[i]  = DW'($urandom);
          waits[i]   = 0;
          set_req(i, op != 1, op != 0, p_addr[i], p_data[i]);
        end else if (r < 6) begin
          clr_req(i);
          req[i] = 1'b1;
        end else begin
          clr_req(i);
        end
      end
      if (p_valid[i]) any = 1'b1;
    end
    if (!any) begin
      f = $urandom_range(0, 3);
      p_valid[f] = 1'b1;
      p_wr[f]    = 1'b0;
      p_addr[f]  = AW'($urandom_range(0, 15));
      p_data[f]  = '0;
      waits[f]   = 0;
      set_req(f, 1'b1, 1'b0, p_addr[f], p_data[f]);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_tests++; if (resp !== 4'b0) begin n_fail++; $display("FAIL reset_resp: got %b expected 0000", resp); end
    n_tests++; if (grant !== 4'b0) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    n_tests++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
    n_tests++; if ({mem_re, mem_we} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b expected 00", {mem_re, mem_we}); end
    n_tests++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
    n_tests++; if (mem_wdata !== '0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", mem_wdata); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
  endtask

  task automatic test_single_read();
    bit ok;
    mem[14'h0123] = 8'hA5;
    set_req(0, 1'b1, 1'b0, 14'h0123, 16'h0000);
    @(negedge clk);
    n_tests++; if ({mem_re, mem_we} !== 2'b10) begin n_fail++; $display("FAIL read_strobe_latency: got re/we %b expected 10", {mem_re, mem_we}); end
    n_tests++; if (mem_addr !== 14'h0123) begin n_fail++; $display("FAIL read_addr: got %h expected 0123", mem_addr); end
    n_tests++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL read_grant: got %b expected 0001", grant); end
    wait_resp(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL read_resp_timeout: got none expected 0001"); end
    n_tests++; if (resp !== 4'b0001) begin n_fail++; $display("FAIL read_resp: got %b expected 0001", resp); end
    n_tests++; if (rdata !== 8'hA5) begin n_fail++; $display("FAIL read_rdata: got %h expected a5", rdata); end
    n_tests++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL read_done_grant: got %b expected 0001", grant); end
    clr_req(0);
    @(negedge clk);
    n_tests++; if (resp !== 4'b0) begin n_fail++; $display("FAIL read_resp_pulse: got %b expected 0000", resp); end
    n_tests++; if (grant !== 4'b0) begin n_fail++; $display("FAIL read_idle_grant: got %b expected 0000", grant); end
  endtask

  task automatic test_single_write();
    bit ok;
    set_req(2, 1'b0, 1'b1, 14'h3FFF, 16'hBEEF);
    @(negedge clk);
    n_tests++; if ({mem_re, mem_we} !== 2'b01) begin n_fail++; $display("FAIL write_strobe: got re/we %b expected 01", {mem_re, mem_we}); end
    n_tests++; if (mem_addr !== 14'h3FFF) begin n_fail++; $display("FAIL write_addr: got %h expected 3fff", mem_addr); end
    n_tests++; if (mem_wdata !== 16'hBEEF) begin n_fail++; $display("FAIL write_wdata: got %h expected beef", mem_wdata); end
    wait_resp(ok);
    n_tests++; if (resp !== 4'b0100) begin n_fail++; $display("FAIL write_resp: got %b expected 0100", resp); end
    n_tests++; if (rdata !== 8'hA5) begin n_fail++; $display("FAIL write_rdata_held: got %h expected a5", rdata); end
    clr_req(2);
    @(negedge clk);
  endtask

  task automatic test_rd_wr_both();
    bit ok;
    set_req(1, 1'b1, 1'b1, 14'h0042, 16'h00FF);
    @(negedge clk);
    n_tests++; if ({mem_re, mem_we} !== 2'b01) begin n_fail++; $display("FAIL rdwr_write_wins: got re/we %b expected 01", {mem_re, mem_we}); end
    n_tests++; if (mem_wdata !== 16'h00FF) begin n_fail++; $display("FAIL rdwr_wdata: got %h expected 00ff", mem_wdata); end
    wait_resp(ok);
    n_tests++; if (resp !== 4'b0010) begin n_fail++; $display("FAIL rdwr_resp: got %b expected 0010", resp); end
    clr_req(1);
    @(negedge clk);
  endtask

  task automatic test_skip_no_op();
    bit ok, seen;
    seen = 1'b0;
    req[0] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (mem_re || mem_we || grant != 4'b0) seen = 1'b1;
    end
    n_tests++; if (seen) begin n_fail++; $display("FAIL skip_no_op: got an access expected none"); end
    set_req(3, 1'b1, 1'b0, 14'h0123, 16'h0000);
    @(negedge clk);
    n_tests++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL skip_grant: got %b expected 1000", grant); end
    wait_resp(ok);
    n_tests++; if (resp !== 4'b1000) begin n_fail++; $display("FAIL skip_resp: got %b expected 1000", resp); end
    clr_req(0); clr_req(3);
    @(negedge clk);
  endtask

  task automatic test_contention();
    bit ok;
    logic [3:0] g;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, AW'(i), 16'h0000);
    for (int n = 0; n < 5; n++) begin
      wait_strobe(ok);
      g = grant;
      n_tests++; if (!ok || g !== 4'(1 << (n % 4))) begin n_fail++; $display("FAIL contention_grant%0d: got %b expected %b", n, g, 4'(1 << (n % 4))); end
      wait_resp(ok);
      n_tests++; if (!ok || resp !== g) begin n_fail++; $display("FAIL contention_resp%0d: got %b expected %b", n, resp, g); end
      if (n == 4) begin req = '0; rd = '0; wr = '0; end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok, seen;
    hang = 1'b1;
    set_req(1, 1'b1, 1'b0, 14'h0055, 16'h0000);
    wait_strobe(ok);
    n_tests++; if (!ok || grant !== 4'b0010) begin n_fail++; $display("FAIL midrst_pre_grant: got %b expected 0010", grant); end
    #2 reset_n = 1'b0;
    #1;
    n_tests++; if ({grant, resp, mem_re, mem_we} !== 10'b0) begin n_fail++; $display("FAIL midrst_async: got grant %b resp %b re %b we %b expected all 0", grant, resp, mem_re, mem_we); end
    n_tests++; if (mem_addr !== '0) begin n_fail++; $display("FAIL midrst_addr: got %h expected 0", mem_addr); end
    req = '0; rd = '0; wr = '0; hang = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp != 4'b0 || mem_re || mem_we) seen = 1'b1;
    end
    n_tests++; if (seen) begin n_fail++; $display("FAIL midrst_no_resp: got activity expected none"); end
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 14'h0123, 16'h0000);
    wait_strobe(ok);
    n_tests++; if (!ok || grant !== 4'b0001) begin n_fail++; $display("FAIL midrst_first_grant: got %b expected 0001", grant); end
    req = '0; rd = '0; wr = '0;
    wait_resp(ok);
    n_tests++; if (resp !== 4'b0001) begin n_fail++; $display("FAIL midrst_drop_resp: got %b expected 0001", resp); end
    n_tests++; if (rdata !== 8'hA5) begin n_fail++; $display("FAIL midrst_rdata: got %h expected a5", rdata); end
    @(negedge clk);
    set_req(3, 1'b1, 1'b0, 14'h0123, 16'h0000);
    wait_strobe(ok);
    n_tests++; if (!ok || grant !== 4'b1000) begin n_fail++; $display("FAIL midrst_req3_grant: got %b expected 1000", grant); end
    wait_resp(ok);
    n_tests++; if (resp !== 4'b1000) begin n_fail++; $display("FAIL midrst_req3_resp: got %b expected 1000", resp); end
    clr_req(3);
    @(negedge clk);
  endtask

  task automatic test_random(input int ntx);
    int w, done, guard;
    bit in_acc;
    bit [7:0] b;
    logic [3:0] eg;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      mem[i] = b;
      ref_mem[i] = b;
    end
    for (int i = 0; i < 4; i++) begin p_valid[i] = 1'b0; waits[i] = 0; end
    ref_rdata = '0;
    m_last = 3;
    w = 0;
    exp_q.delete();
    refill();
    in_acc = 1'b0; done = 0; guard = 0;
    while (done < ntx && guard < 5000) begin
      @(negedge clk);
      guard++;
      if ((mem_re || mem_we) && !in_acc) begin
        in_acc = 1'b1;
        w = -1;
        for (int k = 1; k <= 4; k++)
          if (w < 0 && p_valid[(m_last + k) % 4]) w = (m_last + k) % 4;
        if (w < 0) w = 0;
        exp_q.push_back(4'(1 << w));
        n_tests++; if (grant !== 4'(1 << w)) begin n_fail++; $display("FAIL rand_grant: got %b expected %b", grant, 4'(1 << w)); end
        n_tests++; if ({mem_re, mem_we} !== (p_wr[w] ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL rand_op: got re/we %b expected wr=%0d", {mem_re, mem_we}, p_wr[w]); end
        n_tests++; if (mem_addr !== p_addr[w]) begin n_fail++; $display("FAIL rand_addr: got %h expected %h", mem_addr, p_addr[w]); end
        if (p_wr[w]) begin
          n_tests++; if (mem_wdata !== p_data[w]) begin n_fail++; $display("FAIL rand_wdata: got %h expected %h", mem_wdata, p_data[w]); end
        end
        n_tests++; if (waits[w] > 3) begin n_fail++; $display("FAIL rand_fairness: got %0d waits expected <=3", waits[w]); end
      end
      if (resp != 4'b0) begin
        eg = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0000;
        n_tests++; if (resp !== eg) begin n_fail++; $display("FAIL rand_resp: got %b expected %b", resp, eg); end
        if (p_wr[w]) ref_mem[p_addr[w][3:0]] = p_data[w][7:0];
        else         ref_rdata = ref_mem[p_addr[w][3:0]];
        n_tests++; if (rdata !== ref_rdata) begin n_fail++; $display("FAIL rand_rdata: got %h expected %h", rdata, ref_rdata); end
        for (int i = 0; i < 4; i++) if (i != w && p_valid[i]) waits[i]++;
        m_last = w;
        p_valid[w] = 1'b0;
        clr_req(w);
        in_acc = 1'b0;
        done++;
        refill();
      end
    end
    n_tests++; if (done < ntx) begin n_fail++; $display("FAIL rand_progress: got %0d completions expected %0d", done, ntx); end
    req = '0; rd = '0; wr = '0;
    repeat (8) @(negedge clk);
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int cnt;
    do_reset();
    hang = 1'b1;
    set_req(0, 1'b1, 1'b0, 14'h0010, 16'h0000);
    set_req(1, 1'b1, 1'b0, 14'h0011, 16'h0000);
    wait_strobe(ok);
    cnt = ok ? 1 : 0;
    while ((mem_re || mem_we) && cnt < 200) begin
      @(negedge clk);
      if (mem_re || mem_we) cnt++;
    end
    n_tests++; if (cnt != 64) begin n_fail++; $display("FAIL tmo_cycles: got %0d expected 64", cnt); end
    n_tests++; if (resp !== 4'b0001) begin n_fail++; $display("FAIL tmo_resp: got %b expected 0001", resp); end
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b expected 1", err); end
    n_tests++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL tmo_rdata: got %h expected 00", rdata); end
    clr_req(0);
    hang = 1'b0;
    wait_strobe(ok);
    n_tests++; if (!ok || grant !== 4'b0010) begin n_fail++; $display("FAIL tmo_next_grant: got %b expected 0010", grant); end
    wait_resp(ok);
    n_tests++; if (resp !== 4'b0010) begin n_fail++; $display("FAIL tmo_next_resp: got %b expected 0010", resp); end
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_err_sticky: got %b expected 1", err); end
    clr_req(1);
    @(negedge clk);
  endtask
`endif

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_rd_wr_both();
    test_skip_no_op();
    test_contention();
    test_reset_mid();
    test_random(60);
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`else
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_tied_low: got %b expected 0", err); end
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
